// File: rtl/q_pkg.sv
// Shared types and compare rule for the Q-value argmax pipeline.
// Defining QARGMAX_SIGNED_EN makes every Q-value compare two's-complement.
package q_pkg;

   localparam int Q_DATA_W    = 16;
   localparam int Q_N_ACTIONS = 9;
   localparam int Q_IDX_W     = 6;   // wide enough for the 64-action maximum

   typedef logic [Q_DATA_W-1:0] q_val_t;

   typedef struct packed {
      logic               legal;
      q_val_t             value;
      logic [Q_IDX_W-1:0] idx;
   } q_cand_t;

   // 1 when b replaces a; a holds the lower index, so equal values keep a.
   function automatic logic q_better(input q_cand_t a, input q_cand_t b);
      logic gt;
`ifdef QARGMAX_SIGNED_EN
      gt = $signed(b.value) > $signed(a.value);
`else
      gt = b.value > a.value;
`endif
      return b.legal && (!a.legal || gt);
   endfunction

   // Number of candidates entering tree level l for an n-input tree.
   function automatic int q_lvl_w(input int n, input int l);
      return (n + (1 << l) - 1) >> l;
   endfunction

endpackage

// File: rtl/q_cmp_node.sv
// One node of the argmax tree: keeps the better of two candidates.
module q_cmp_node
   import q_pkg::*;
(
   input  q_cand_t a_i,
   input  q_cand_t b_i,
   output q_cand_t y_o
);

   assign y_o = q_better(a_i, b_i) ? b_i : a_i;

endmodule

// File: rtl/q_argmax_pipe.sv
// Pipelined masked argmax over N_IN Q-values, one register per tree level.
// Build option QARGMAX_SIGNED_EN selects signed Q-values (see q_pkg).
module q_argmax_pipe
   import q_pkg::*;
#(
   parameter int N_IN   = Q_N_ACTIONS,
   parameter int DATA_W = Q_DATA_W,
   parameter int IDX_W  = $clog2(N_IN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN*DATA_W-1:0] in_q,
   input  logic [N_IN-1:0]        in_mask,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_q,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_none
);

   localparam int LEVELS = $clog2(N_IN);

   logic    en;
   q_cand_t root;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   genvar l, k;
   for (l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int WI = q_lvl_w(N_IN, l);
      localparam int WO = q_lvl_w(N_IN, l + 1);

      q_cand_t in_c  [WI];
      q_cand_t res_d [WO];
      q_cand_t res_q [WO];
      logic    vld_in;
      logic    vld_q;

      if (l == 0) begin : g_src
         for (k = 0; k < WI; k++) begin : g_leaf
            logic [DATA_W-1:0] raw;
            q_val_t            ext;
            assign raw = in_q[k*DATA_W +: DATA_W];
`ifdef QARGMAX_SIGNED_EN
            assign ext = Q_DATA_W'(signed'(raw));
`else
            assign ext = Q_DATA_W'(raw);
`endif
            assign in_c[k] = '{in_mask[k], ext, Q_IDX_W'(k)};
         end
         assign vld_in = in_valid;
      end else begin : g_src
         for (k = 0; k < WI; k++) begin : g_fwd
            assign in_c[k] = g_lvl[l-1].res_q[k];
         end
         assign vld_in = g_lvl[l-1].vld_q;
      end

      for (k = 0; k < WO; k++) begin : g_node
         if (2*k + 1 < WI) begin : g_cmp
            q_cmp_node u_node (
               .a_i (in_c[2*k]),
               .b_i (in_c[2*k+1]),
               .y_o (res_d[k])
            );
         end else begin : g_pad
            // Pairing with an illegal pad always returns the lone operand.
            assign res_d[k] = in_c[2*k];
         end
      end

      always_ff @(posedge clk) begin
         if (en) res_q <= res_d;
      end

      always_ff @(posedge clk) begin
         if (!rst_n)  vld_q <= 1'b0;
         else if (en) vld_q <= vld_in;
      end
   end

   // Result fields are gated by valid so the root data needs no reset.
   assign root      = g_lvl[LEVELS-1].res_q[0];
   assign out_valid = g_lvl[LEVELS-1].vld_q;
   assign out_none  = out_valid && !root.legal;
   assign out_q     = (out_valid && root.legal) ? DATA_W'(root.value) : '0;
   assign out_idx   = (out_valid && root.legal) ? IDX_W'(root.idx) : '0;

endmodule

// File: doc/q_argmax_pipe.md
Name: q_argmax_pipe

Overview:
- Pipelined, parametrised successor to the 9-input combinational Q-value max tree used by the tic-tac-toe Q-learning agent.
- Accepts one vector of N_IN Q-values per beat, together with a legal-move mask.
- Returns the maximum legal Q-value and its action index (argmax) through a registered balanced tree, one register stage per tree level.
- Sits between the Q-table read port and the action-select/update logic; valid/ready handshakes on both sides.

Parameters:
- N_IN, 9, number of Q-values (actions) per vector; legal range 2..64.
- DATA_W, 16, width of each Q-value.
- IDX_W, $clog2(N_IN), width of the action index.
- LEVELS, $clog2(N_IN), tree depth; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_q  input  N_IN*DATA_W  packed Q-values; element i = in_q[i*DATA_W +: DATA_W].
- in_mask  input  N_IN  1 = action i legal (cell empty); 0 = excluded from compare.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_q  output  DATA_W  maximum legal Q-value.
- out_idx  output  IDX_W  index of that value.
- out_none  output  1  1 = no legal action in the vector (mask all zero).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
- Reset: all stage-valid bits cleared; out_valid=0, out_q=0, out_idx=0, out_none=0; in_ready=1 the cycle after reset deasserts. A reset mid-operation discards every in-flight vector; no partial result is emitted.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stall: global pipeline enable en = !out_valid || out_ready; in_ready = en. While en=0 every stage register, including outputs, holds its value. out_q, out_idx and out_none remain stable while out_valid && !out_ready.
- Latency: LEVELS cycles from input transfer to out_valid when en stays 1 (N_IN=9 gives 4). Throughput is one vector per cycle.
- Leaf stage: each element becomes a triple (legal, value, index). Odd counts at any level pad with an illegal entry.
- Compare node, for operands a and b with a at the lower index:
  - Both illegal: result illegal.
  - Exactly one legal: result is the legal operand.
  - Both legal: b wins only if b.value > a.value (strict), otherwise a.
  - Ties therefore resolve to the lowest index.
- Comparison is unsigned by default (see Optional Feature).
- Final stage:
  - Root triple illegal: out_none=1, out_q=0, out_idx=0.
  - Otherwise out_none=0, out_q/out_idx taken from the root triple.
- Bubbles (in_valid=0 while en=1) propagate as invalid stages. No bubble collapse.
- in_q and in_mask need not be stable outside the transfer cycle.

Optional Feature:
- Macro QARGMAX_SIGNED_EN.
- Defined: Q-values are two's-complement; every compare is signed, so 16'hFFFF (-1) < 16'h0000.
- Undefined: unsigned compare, so 16'hFFFF is the maximum.
- Handshake, latency and tie rules are identical in both builds.

Decomposition:
- Package q_pkg holds:
  - constants Q_DATA_W=16 and Q_N_ACTIONS=9;
  - typedef q_val_t (logic [Q_DATA_W-1:0]);
  - typedef q_cand_t, a packed struct {legal, value, idx};
  - function q_better(a,b), which encodes the compare rule and the macro-dependent signedness.
- Sub-module q_cmp_node: combinational compare of two q_cand_t producing one q_cand_t. q_argmax_pipe instantiates it in a generate loop per level, with registers between levels.

Test Plan:
1. Reset, N_IN=9: mask=9'h1FF, values 3,7,2,9,1,9,0,4,5, out_ready=1 -> after 4 cycles out_q=9, out_idx=3 (lowest-index tie), out_none=0.
2. Masking: same values, mask=9'h1F7 (idx 3 illegal) -> out_q=9, out_idx=5. Then mask=9'h000 -> out_none=1, out_q=0, out_idx=0.
3. Back-to-back and backpressure:
   - Drive 6 vectors on consecutive cycles with out_ready=1, then hold out_ready=0 for 5 cycles.
   - Required: in_ready=0 while out_valid && !out_ready; output held stable; all 6 results delivered in order with none lost or duplicated.
4. Reset mid-flight: drive 3 vectors, assert rst_n=0 for one cycle before the first output -> out_valid stays 0 and no stale result appears afterwards.
5. Sign: values 16'hFFFF at idx0 and 16'h0001 at idx1, others masked off.
   - Macro undefined -> out_idx=0.
   - QARGMAX_SIGNED_EN defined -> out_idx=1, out_q=16'h0001.
6. Parameter sweep: N_IN=2,5,16 and DATA_W=8 with random vectors and masks against a reference model -> exact match on out_q, out_idx and out_none; latency = $clog2(N_IN).
